// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx: assembles SYNC/HI/LO/CHK byte frames from the UART receiver
// into a 16-bit command word for the shutter position controller. A good
// checksum (CHK == HI ^ LO) publishes {HI,LO} with a one-cycle WR pulse.
// A bad checksum or an inter-byte stall produces a one-cycle frame_err pulse.
module cmd_frame_rx #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned TO_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] byte_data_received,
  output logic        WR,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    S_HI  = 2'd1,
    S_LO  = 2'd2,
    S_CHK = 2'd3
  } state_e;

  // Count value at which a stalled frame is abandoned, and the saturation cap.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};

  // Frame checksum: XOR of the two payload bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] hi, input logic [7:0] lo);
    return hi ^ lo;
  endfunction

  state_e           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       lo_q, lo_d;
  logic [15:0]      data_q, data_d;
  logic             wr_q, wr_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  // Next-state, payload capture, timeout and pulse generation.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    data_d   = data_q;
    wr_d     = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        to_cnt_d = {TO_W{1'b0}};
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = S_HI;
        end else begin
          state_d = IDLE;
        end
      end

      S_HI, S_LO, S_CHK: begin
        if (rx_valid) begin
          // An arriving byte always wins over an expiring counter.
          to_cnt_d = {TO_W{1'b0}};
          if (state_q == S_HI) begin
            hi_d    = rx_data;
            state_d = S_LO;
          end else if (state_q == S_LO) begin
            lo_d    = rx_data;
            state_d = S_CHK;
          end else begin
            if (rx_data == frame_chk(hi_q, lo_q)) begin
              data_d = {hi_q, lo_q};
              wr_d   = 1'b1;
            end else begin
              err_d  = 1'b1;
            end
            state_d = IDLE;
          end
        end else if (to_cnt_q >= TO_LAST) begin
          state_d  = IDLE;
          err_d    = 1'b1;
          to_cnt_d = {TO_W{1'b0}};
        end else if (to_cnt_q != TO_MAX) begin
          to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
          to_cnt_d = to_cnt_q;
        end
      end

      default: begin
        state_d  = IDLE;
        to_cnt_d = {TO_W{1'b0}};
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; async reset drops any partial frame silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      to_cnt_q <= {TO_W{1'b0}};
      hi_q     <= 8'h00;
      lo_q     <= 8'h00;
      data_q   <= 16'h0000;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign byte_data_received = data_q;
  assign WR                 = wr_q;
  assign frame_err          = err_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Self-checking bench for cmd_frame_rx: directed scenarios plus randomized
// frames, compared against a queue-based frame model kept in the bench.
module tb_cmd_frame_rx;

  localparam int         TO   = 40;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] byte_data_received;
  logic        WR;
  logic        frame_err;
  logic        busy;

  cmd_frame_rx #(
    .SYNC_BYTE  (SYNC),
    .TIMEOUT_CYC(TO),
    .TO_W       (16)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .byte_data_received(byte_data_received),
    .WR                (WR),
    .frame_err         (frame_err),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: bytes of the frame in progress, and cycle stamps.
  logic [7:0]  fq[$];
  longint      cyc = 0;
  longint      last_cyc = 0;
  logic        m_wr, m_err, m_busy;
  logic [15:0] m_data;

  // Observation counters over the current scenario.
  int wr_cnt, err_cnt, m_wr_cnt, m_err_cnt, diverge;

  function void model_reset();
    fq.delete();
    m_wr = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_data = 16'h0000;
  endfunction

  // One clock of the frame rules: a frame is SYNC followed by three bytes,
  // and a frame in progress is dropped TO cycles after its last byte.
  function void model_step(input logic v, input logic [7:0] d);
    cyc++;
    m_wr = 1'b0; m_err = 1'b0;
    if (v) begin
      if (fq.size() != 0 || d == SYNC) begin
        fq.push_back(d);
        last_cyc = cyc;
      end
      if (fq.size() == 4) begin
        if (fq[3] == (fq[1] ^ fq[2])) begin
          m_wr = 1'b1; m_data = {fq[1], fq[2]};
        end else begin
          m_err = 1'b1;
        end
        fq.delete();
      end
    end else if (fq.size() != 0 && (cyc - last_cyc) >= TO) begin
      m_err = 1'b1;
      fq.delete();
    end
    m_busy = (fq.size() != 0);
  endfunction

  task automatic clr_counts();
    wr_cnt = 0; err_cnt = 0; m_wr_cnt = 0; m_err_cnt = 0; diverge = 0;
  endtask

  // Drive one cycle, advance the model, then observe just after the edge.
  task automatic tick(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model_step(v, d);
    #1;
    rx_valid = 1'b0;
    if (WR === 1'b1) wr_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (m_wr) m_wr_cnt++;
    if (m_err) m_err_cnt++;
    if (WR !== m_wr || frame_err !== m_err || byte_data_received !== m_data ||
        busy !== m_busy || (WR === 1'b1 && frame_err === 1'b1))
      diverge++;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    tick(1'b1, b);
    for (int i = 0; i < gap; i++) tick(1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++; if (byte_data_received !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h expected 0000", byte_data_received); end
    tests++; if (WR !== 1'b0) begin fails++; $display("FAIL reset_wr: got %b expected 0", WR); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_good_frame();
    clr_counts();
    send(8'hA5, 10); send(8'h00, 10); send(8'hC8, 10);
    tick(1'b1, 8'hC8);
    tests++; if (WR !== 1'b1) begin fails++; $display("FAIL good_latency: WR got %b expected 1", WR); end
    for (int i = 0; i < 10; i++) tick(1'b0, 8'h00);
    tests++; if (wr_cnt != 1) begin fails++; $display("FAIL good_wr_count: got %0d expected 1", wr_cnt); end
    tests++; if (err_cnt != 0) begin fails++; $display("FAIL good_err_count: got %0d expected 0", err_cnt); end
    tests++; if (byte_data_received !== 16'h00C8) begin fails++; $display("FAIL good_data: got %h expected 00c8", byte_data_received); end
    tests++; if (diverge != 0) begin fails++; $display("FAIL good_model: %0d cycles differ, expected 0", diverge); end
  endtask

  task automatic test_bad_checksum();
    clr_counts();
    send(8'hA5, 2); send(8'h12, 2); send(8'h34, 2);
    tick(1'b1, 8'h00);
    tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL bad_latency: frame_err got %b expected 1", frame_err); end
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00);
    tests++; if (wr_cnt != 0) begin fails++; $display("FAIL bad_wr_count: got %0d expected 0", wr_cnt); end
    tests++; if (err_cnt != 1) begin fails++; $display("FAIL bad_err_count: got %0d expected 1", err_cnt); end
    tests++; if (byte_data_received !== 16'h00C8) begin fails++; $display("FAIL bad_data_held: got %h expected 00c8", byte_data_received); end
    tests++; if (diverge != 0) begin fails++; $display("FAIL bad_model: %0d cycles differ, expected 0", diverge); end
  endtask

  task automatic test_garbage();
    clr_counts();
    send(8'h00, 1); send(8'hFF, 1); send(8'h5A, 1);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL garbage_busy: got %b expected 0", busy); end
    send(8'hA5, 1); send(8'h01, 1); send(8'h02, 1); send(8'h03, 3);
    tests++; if (err_cnt != 0) begin fails++; $display("FAIL garbage_err_count: got %0d expected 0", err_cnt); end
    tests++; if (wr_cnt != 1) begin fails++; $display("FAIL garbage_wr_count: got %0d expected 1", wr_cnt); end
    tests++; if (byte_data_received !== 16'h0102) begin fails++; $display("FAIL garbage_data: got %h expected 0102", byte_data_received); end
    tests++; if (diverge != 0) begin fails++; $display("FAIL garbage_model: %0d cycles differ, expected 0", diverge); end
  endtask

  task automatic test_timeout();
    clr_counts();
    send(8'hA5, 0); send(8'h10, 0);
    for (int i = 0; i < TO - 1; i++) tick(1'b0, 8'h00);
    tests++; if (busy !== 1'b1 || err_cnt != 0) begin fails++; $display("FAIL timeout_early: busy %b errs %0d expected busy 1 errs 0", busy, err_cnt); end
    tick(1'b0, 8'h00);
    tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL timeout_pulse: got %b expected 1", frame_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL timeout_busy: got %b expected 0", busy); end
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00);
    send(8'hA5, 1); send(8'h00, 1); send(8'h40, 1); send(8'h40, 2);
    tests++; if (err_cnt != 1) begin fails++; $display("FAIL timeout_err_count: got %0d expected 1", err_cnt); end
    tests++; if (wr_cnt != 1 || byte_data_received !== 16'h0040) begin fails++; $display("FAIL timeout_recover: wr %0d data %h expected 1 0040", wr_cnt, byte_data_received); end
    tests++; if (diverge != 0) begin fails++; $display("FAIL timeout_model: %0d cycles differ, expected 0", diverge); end
  endtask

  task automatic test_expiry_accept();
    clr_counts();
    send(8'hA5, 0); send(8'h11, 0); send(8'h22, TO - 1);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL expiry_busy: got %b expected 1", busy); end
    tick(1'b1, 8'h33);
    for (int i = 0; i < TO + 2; i++) tick(1'b0, 8'h00);
    tests++; if (wr_cnt != 1 || err_cnt != 0) begin fails++; $display("FAIL expiry_accept: wr %0d err %0d expected 1 0", wr_cnt, err_cnt); end
    tests++; if (byte_data_received !== 16'h1122) begin fails++; $display("FAIL expiry_data: got %h expected 1122", byte_data_received); end
    tests++; if (diverge != 0) begin fails++; $display("FAIL expiry_model: %0d cycles differ, expected 0", diverge); end
  endtask

  task automatic test_reset_mid();
    clr_counts();
    send(8'hA5, 1); send(8'h7F, 0);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (byte_data_received !== 16'h0000 || WR !== 1'b0 || frame_err !== 1'b0) begin fails++; $display("FAIL midreset_out: data %h wr %b err %b expected 0000 0 0", byte_data_received, WR, frame_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    clr_counts();
    for (int i = 0; i < TO + 4; i++) tick(1'b0, 8'h00);
    tests++; if (wr_cnt != 0 || err_cnt != 0) begin fails++; $display("FAIL midreset_pulses: wr %0d err %0d expected 0 0", wr_cnt, err_cnt); end
    send(8'hA5, 1); send(8'hA5, 1); send(8'h00, 1); send(8'hA5, 2);
    tests++; if (wr_cnt != 1 || byte_data_received !== 16'hA500) begin fails++; $display("FAIL sync_as_data: wr %0d data %h expected 1 a500", wr_cnt, byte_data_received); end
    tests++; if (diverge != 0) begin fails++; $display("FAIL midreset_model: %0d cycles differ, expected 0", diverge); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] h, l;
    clr_counts();
    h = 8'($urandom); l = 8'($urandom);
    send(8'hA5, 0); send(h, 0); send(l, 0); send(h ^ l, 0);
    h = 8'($urandom); l = 8'($urandom);
    send(8'hA5, 0); send(h, 0); send(l, 0); send(h ^ l, 2);
    tests++; if (wr_cnt != 2 || err_cnt != 0) begin fails++; $display("FAIL b2b_count: wr %0d err %0d expected 2 0", wr_cnt, err_cnt); end
    tests++; if (byte_data_received !== {h, l}) begin fails++; $display("FAIL b2b_data: got %h expected %h", byte_data_received, {h, l}); end
    tests++; if (diverge != 0) begin fails++; $display("FAIL b2b_model: %0d cycles differ, expected 0", diverge); end
  endtask

  task automatic test_random();
    logic [7:0] h, l, c;
    int kind, gap;
    clr_counts();
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 4);
      h = 8'($urandom); l = 8'($urandom); c = h ^ l;
      if (kind == 1) c = c ^ 8'(1 << $urandom_range(0, 7));
      if (kind == 2) begin
        send(8'($urandom), $urandom_range(0, 2));
      end else begin
        gap = (kind == 4) ? TO - 1 : $urandom_range(0, 3);
        send(8'hA5, gap); send(h, gap);
        if (kind == 3) begin
          send(l, TO + $urandom_range(0, 3));
        end else begin
          send(l, gap); send(c, $urandom_range(0, 2));
        end
      end
    end
    for (int i = 0; i < TO + 2; i++) tick(1'b0, 8'h00);
    tests++; if (wr_cnt != m_wr_cnt) begin fails++; $display("FAIL rand_wr_count: got %0d expected %0d", wr_cnt, m_wr_cnt); end
    tests++; if (err_cnt != m_err_cnt) begin fails++; $display("FAIL rand_err_count: got %0d expected %0d", err_cnt, m_err_cnt); end
    tests++; if (byte_data_received !== m_data) begin fails++; $display("FAIL rand_data: got %h expected %h", byte_data_received, m_data); end
    tests++; if (diverge != 0) begin fails++; $display("FAIL rand_model: %0d cycles differ, expected 0", diverge); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_garbage();
    test_timeout();
    test_expiry_accept();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cmd_frame_rx.md
Name: cmd_frame_rx

Overview:
Command frame assembler sitting directly upstream of the shutter position controller.
- Consumes a byte stream from the UART receiver and validates 4-byte frames: SYNC, HI, LO, CHK.
- Presents the 16-bit command word on byte_data_received with a one-cycle WR strobe.
- The position controller samples byte_data_received[7:0] as its angle target; bits [15:8] are reserved for a device/channel field.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYC, 50000, max clk cycles allowed between consecutive bytes of one frame
TO_W, 16, width of inter-byte timeout counter (must hold TIMEOUT_CYC-1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  byte from UART receiver
rx_valid  input  1  one-cycle strobe, rx_data valid this cycle
byte_data_received  output  16  last valid command word {HI,LO}, held until next valid frame
WR  output  1  one-cycle pulse, new command word valid
frame_err  output  1  one-cycle pulse, checksum fail or inter-byte timeout
busy  output  1  high while a frame is partially received (state != IDLE)

Behaviour:
- Reset (async, rst_n=0) clears all state immediately:
  - byte_data_received=16'h0000, WR=0, frame_err=0, busy=0
  - state=IDLE, timeout counter=0, HI/LO holding registers=0
- Reset mid-frame discards the partial frame; no WR or frame_err pulse is generated.
- State machine, all transitions on posedge clk:
  - IDLE: rx_valid with rx_data==SYNC_BYTE -> S_HI. Any other byte is ignored silently, with no frame_err.
  - S_HI: rx_valid -> latch hi=rx_data -> S_LO.
  - S_LO: rx_valid -> latch lo=rx_data -> S_CHK.
  - S_CHK: rx_valid -> compare rx_data against hi^lo, then -> IDLE.
    - Match: byte_data_received<={hi,lo}; WR=1 on the next cycle only.
    - Mismatch: frame_err=1 on the next cycle only; byte_data_received unchanged.
- Data bytes equal to SYNC_BYTE inside a frame are treated as data; there is no mid-frame resync.
- Latency: WR rises on the first clk edge after the cycle in which the CHK byte is strobed. byte_data_received updates on that same edge.
- WR and frame_err are registered, never both high, and never high for more than one cycle.
- Timeout counter:
  - Cleared to 0 in IDLE and on every accepted rx_valid.
  - Increments by 1 each cycle in S_HI, S_LO and S_CHK without rx_valid.
  - On reaching TIMEOUT_CYC-1 with no rx_valid in that cycle: state -> IDLE and frame_err pulses next cycle.
  - If rx_valid coincides with the expiry cycle, the byte wins: it is accepted, the counter clears, and no timeout occurs.
  - The counter saturates and never wraps.
- Back-to-back frames: the SYNC of the next frame may arrive in the cycle immediately after the CHK byte. It is accepted, because the FSM is already in IDLE when it is sampled.
- rx_valid is assumed single-cycle per byte. A held rx_valid counts as one byte per cycle.
- busy = (state != IDLE), registered.

Test Plan:
- Reset, then bytes A5,00,C8,C8 at 10-cycle spacing -> one WR pulse one cycle after the CHK strobe; byte_data_received=16'h00C8; frame_err stays 0.
- Bytes A5,12,34,00 (bad checksum; correct is 26) -> frame_err pulse, no WR; byte_data_received keeps its prior value 16'h00C8.
- Garbage 00,FF,5A, then A5,01,02,03 -> garbage ignored with no frame_err; WR with byte_data_received=16'h0102.
- Bytes A5,10, then silence for TIMEOUT_CYC cycles -> frame_err pulse; busy drops to 0. A following valid frame A5,00,40,40 -> WR with 16'h0040.
- CHK byte delivered exactly in the expiry cycle (TIMEOUT_CYC-1 idle cycles after LO) -> accepted, WR pulses, no frame_err.
- rst_n low after A5,7F -> outputs zero immediately, busy=0, no pulses. After release, frame A5,A5,00,A5 -> WR with 16'hA500, confirming SYNC is treated as data mid-frame.
